sdram_dbus_arbiter: RTL and testbench



---
 rtl/sdram_pkg.sv | 15 +
 rtl/sdram_rr_pick.sv | 30 +++
 rtl/sdram_dbus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sdram_dbus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared constants and arbiter state encoding for the SDRAM controller front end.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_WIDTH  = 25;
  localparam int unsigned SDRAM_DATA_WIDTH  = 16;
  localparam int unsigned SDRAM_BURST_WIDTH = 7;
  localparam int unsigned BURST_MAX         = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last+1 with wrap.
module sdram_rr_pick #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] pick,
  output logic [IDX_W-1:0]     pick_idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = (32'(last) + k) % NUM_PORTS;
      if (!found && req[IDX_W'(cand)]) begin
        found                = 1'b1;
        pick[IDX_W'(cand)]   = 1'b1;
        pick_idx             = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_dbus_arbiter.sv
// Burst-granular round-robin arbiter sharing the SDRAM controller dbus port between Avalon-MM masters.
module sdram_dbus_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ADDR_WIDTH  = SDRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = SDRAM_DATA_WIDTH,
  parameter int unsigned BURST_WIDTH = SDRAM_BURST_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   m_address,
  input  logic [NUM_PORTS*BURST_WIDTH-1:0]  m_burstcount,
  input  logic [NUM_PORTS-1:0]              m_read,
  input  logic [NUM_PORTS-1:0]              m_write,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   m_writedata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_byteenable,
  output logic [NUM_PORTS-1:0]              m_waitrequest,
  output logic [NUM_PORTS-1:0]              m_readdatavalid,
  output logic [DATA_WIDTH-1:0]             m_readdata,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [BURST_WIDTH-1:0]            s_burstcount,
  output logic                              s_read,
  output logic                              s_write,
  output logic [DATA_WIDTH-1:0]             s_writedata,
  output logic [DATA_WIDTH/8-1:0]           s_byteenable,
  input  logic                              s_waitrequest,
  input  logic                              s_readdatavalid,
  input  logic [DATA_WIDTH-1:0]             s_readdata,
  output logic [NUM_PORTS-1:0]              grant
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  arb_state_e             state_q, state_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [BURST_WIDTH-1:0] beats_q, beats_d;
  logic                   cmd_done_q, cmd_done_d;

  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   pick;
  logic [IDX_W-1:0]       pick_idx;

  logic [ADDR_WIDTH-1:0]  own_addr;
  logic [BURST_WIDTH-1:0] own_bc;
  logic [DATA_WIDTH-1:0]  own_wd;
  logic [BE_W-1:0]        own_be;
  logic                   own_read;
  logic                   own_write;
  logic [BURST_WIDTH-1:0] pick_bc;
  logic                   pick_read;

  assign req = m_read | m_write;

  sdram_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req      (req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // last_q doubles as the owner index while a burst is in flight
  always_comb begin
    own_addr  = '0;
    own_bc    = '0;
    own_wd    = '0;
    own_be    = '0;
    own_read  = 1'b0;
    own_write = 1'b0;
    pick_bc   = '0;
    pick_read = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (IDX_W'(i) == last_q) begin
        own_addr  = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_bc    = m_burstcount[i*BURST_WIDTH +: BURST_WIDTH];
        own_wd    = m_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        own_be    = m_byteenable[i*BE_W +: BE_W];
        own_read  = m_read[i];
        own_write = m_write[i];
      end
      if (IDX_W'(i) == pick_idx) begin
        pick_bc   = m_burstcount[i*BURST_WIDTH +: BURST_WIDTH];
        pick_read = m_read[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_PORTS - 1);
      beats_q    <= '0;
      cmd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beats_q    <= beats_d;
      cmd_done_q <= cmd_done_d;
    end
  end

  // Release is decided on the pre-decrement count so beats never wraps
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beats_d    = beats_q;
    cmd_done_d = cmd_done_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d    = pick;
          last_d     = pick_idx;
          beats_d    = (pick_bc == '0) ? BURST_WIDTH'(1) : pick_bc;
          cmd_done_d = 1'b0;
          state_d    = pick_read ? ARB_READ : ARB_WRITE;
        end
      end
      ARB_WRITE: begin
        if (s_write && !s_waitrequest && (beats_q != '0)) begin
          beats_d = beats_q - BURST_WIDTH'(1);
          if (beats_q == BURST_WIDTH'(1)) begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      ARB_READ: begin
        if (s_read && !s_waitrequest) begin
          cmd_done_d = 1'b1;
        end
        if (s_readdatavalid && (beats_q != '0)) begin
          beats_d = beats_q - BURST_WIDTH'(1);
          if (beats_q == BURST_WIDTH'(1)) begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Command forwarding to the controller and per-master stall/strobe steering
  always_comb begin
    s_address       = own_addr;
    s_burstcount    = own_bc;
    s_writedata     = own_wd;
    s_byteenable    = own_be;
    s_read          = 1'b0;
    s_write         = 1'b0;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    case (state_q)
      ARB_WRITE: begin
        s_write       = own_write;
        m_waitrequest = ~grant_q | {NUM_PORTS{s_waitrequest}};
      end
      ARB_READ: begin
        s_read          = own_read & ~cmd_done_q;
        m_readdatavalid = {NUM_PORTS{s_readdatavalid}} & grant_q;
        if (!cmd_done_q) begin
          m_waitrequest = ~grant_q | {NUM_PORTS{s_waitrequest}};
        end
      end
      default: ;
    endcase
  end

  assign m_readdata = s_readdata;
  assign grant      = grant_q;

endmodule

// File: tb/tb_sdram_dbus_arbiter.sv
// Self-checking bench for sdram_dbus_arbiter: directed vector table, corner sequences, random vs reference model.
module tb_sdram_dbus_arbiter;

  localparam int unsigned NP  = 2;
  localparam int unsigned AW  = 25;
  localparam int unsigned DW  = 16;
  localparam int unsigned BW  = 7;
  localparam int unsigned BEW = DW / 8;
  localparam int unsigned IW  = $clog2(NP);

  logic clk = 1'b0;
  logic rst;

  logic [NP*AW-1:0]  m_address;
  logic [NP*BW-1:0]  m_burstcount;
  logic [NP-1:0]     rd, wr;
  logic [NP*DW-1:0]  m_writedata;
  logic [NP*BEW-1:0] m_byteenable;
  logic [NP-1:0]     m_waitrequest, m_readdatavalid, grant;
  logic [DW-1:0]     m_readdata;
  logic [AW-1:0]     s_address;
  logic [BW-1:0]     s_burstcount;
  logic              s_read, s_write;
  logic [DW-1:0]     s_writedata;
  logic [BEW-1:0]    s_byteenable;
  logic              swait, srdv;
  logic [DW-1:0]     sdata;

  logic [AW-1:0]  addr [NP];
  logic [BW-1:0]  bc   [NP];
  logic [DW-1:0]  wd   [NP];
  logic [BEW-1:0] be   [NP];

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign m_address[g*AW +: AW]     = addr[g];
    assign m_burstcount[g*BW +: BW]  = bc[g];
    assign m_writedata[g*DW +: DW]   = wd[g];
    assign m_byteenable[g*BEW +: BEW] = be[g];
  end

  sdram_dbus_arbiter #(
    .NUM_PORTS   (NP),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BURST_WIDTH (BW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .m_address       (m_address),
    .m_burstcount    (m_burstcount),
    .m_read          (rd),
    .m_write         (wr),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .s_address       (s_address),
    .s_burstcount    (s_burstcount),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (swait),
    .s_readdatavalid (srdv),
    .s_readdata      (sdata),
    .grant           (grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner of the current burst (-1 = free), beats still owed, command taken.
  int owner = -1;
  int remaining = 0;
  int lastp = NP - 1;
  bit is_rd = 1'b0;
  bit cmd_taken = 1'b0;

  task automatic model_update();
    logic [IW-1:0] oi;
    bit found;
    int p;
    oi = IW'(owner < 0 ? 0 : owner);
    if (rst) begin
      owner = -1; lastp = NP - 1; remaining = 0; cmd_taken = 1'b0; is_rd = 1'b0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        p = (lastp + k) % NP;
        if (!found && (rd[IW'(p)] || wr[IW'(p)])) begin
          found = 1'b1;
          owner = p;
          lastp = p;
          is_rd = rd[IW'(p)];
          cmd_taken = 1'b0;
          remaining = (bc[IW'(p)] == 0) ? 1 : int'(bc[IW'(p)]);
        end
      end
    end else if (!is_rd) begin
      if (wr[oi] && !swait) begin
        remaining--;
        if (remaining == 0) owner = -1;
      end
    end else begin
      if (rd[oi] && !cmd_taken && !swait) cmd_taken = 1'b1;
      if (srdv) begin
        remaining--;
        if (remaining == 0) owner = -1;
      end
    end
  endtask

  task automatic cmp_model();
    logic [NP-1:0] eg, emw, erv;
    logic esr, esw;
    logic [IW-1:0] oi;
    eg = '0; emw = '1; erv = '0; esr = 1'b0; esw = 1'b0;
    oi = IW'(owner < 0 ? 0 : owner);
    if (owner >= 0) begin
      eg = NP'(1) << owner;
      if (is_rd) begin
        esr = rd[oi] && !cmd_taken;
        if (!cmd_taken) emw = ~eg | {NP{swait}};
        if (srdv) erv = eg;
      end else begin
        esw = wr[oi];
        emw = ~eg | {NP{swait}};
      end
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("s_read", 32'(s_read), 32'(esr));
    chk("s_write", 32'(s_write), 32'(esw));
    chk("m_waitrequest", 32'(m_waitrequest), 32'(emw));
    chk("m_readdatavalid", 32'(m_readdatavalid), 32'(erv));
    chk("m_readdata", 32'(m_readdata), 32'(sdata));
    if (owner >= 0) begin
      chk("s_address", 32'(s_address), 32'(addr[oi]));
      chk("s_burstcount", 32'(s_burstcount), 32'(bc[oi]));
      chk("s_writedata", 32'(s_writedata), 32'(wd[oi]));
      chk("s_byteenable", 32'(s_byteenable), 32'(be[oi]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  rd, wr;
    logic [6:0]  bc0, bc1;
    logic        sw, rv;
    logic [1:0]  eg;
    logic        esr, esw;
    logic [1:0]  emw, erv;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic [1:0] vrd, input logic [1:0] vwr,
                              input logic [6:0] b0, input logic [6:0] b1, input logic sw,
                              input logic rv, input logic [1:0] eg, input logic esr,
                              input logic esw, input logic [1:0] emw, input logic [1:0] erv);
    vec_t v;
    v.rst = r; v.rd = vrd; v.wr = vwr; v.bc0 = b0; v.bc1 = b1; v.sw = sw; v.rv = rv;
    v.eg = eg; v.esr = esr; v.esw = esw; v.emw = emw; v.erv = erv;
    vq.push_back(v);
  endfunction

  logic [NP-1:0] gq[$];
  logic [NP-1:0] prev_g;
  int rv1, rv0;

  initial begin
    rst = 1'b1; rd = '0; wr = '0; swait = 1'b0; srdv = 1'b0; sdata = 16'hbeef;
    addr[0] = 25'h100; addr[1] = 25'h2000;
    bc[0] = '0; bc[1] = '0;
    wd[0] = 16'h1111; wd[1] = 16'h2222;
    be[0] = 2'b11; be[1] = 2'b01;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_mwait", 32'(m_waitrequest), 32'h3);
    chk("reset_swrite", 32'(s_write), 32'h0);
    chk("reset_sread", 32'(s_read), 32'h0);
    chk("reset_mrdv", 32'(m_readdatavalid), 32'h0);

    // rst rd wr bc0 bc1 sw rv | grant sread swrite mwait mrdv
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 2'b11, 2'b00);  // spurious rdv in idle
    add(0, 2'b00, 2'b01, 4, 0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);  // port0 write x4 requests
    add(0, 2'b00, 2'b01, 4, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b01, 4, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b01, 4, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b01, 4, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);  // released
    add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);  // port1 rd+wr, bc=0
    add(0, 2'b10, 2'b10, 0, 0, 0, 0, 2'b10, 1, 0, 2'b01, 2'b00);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b10, 0, 0, 2'b11, 2'b10);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b00, 0, 0, 2'b11, 2'b00);
    add(0, 2'b00, 2'b01, 2, 0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);  // controller stall
    add(0, 2'b00, 2'b01, 2, 0, 1, 0, 2'b01, 0, 1, 2'b11, 2'b00);
    add(0, 2'b00, 2'b01, 2, 0, 1, 1, 2'b01, 0, 1, 2'b11, 2'b00);
    add(0, 2'b00, 2'b01, 2, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b00, 2, 0, 0, 0, 2'b01, 0, 0, 2'b10, 2'b00);  // write gap
    add(0, 2'b00, 2'b01, 2, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);
    add(0, 2'b00, 2'b01, 8, 0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);  // reset mid-burst
    add(0, 2'b00, 2'b01, 8, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(1, 2'b00, 2'b01, 8, 0, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b11, 1, 1, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);
    add(0, 2'b00, 2'b11, 1, 1, 0, 0, 2'b01, 0, 1, 2'b10, 2'b00);
    add(0, 2'b00, 2'b10, 1, 1, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);
    add(0, 2'b00, 2'b10, 1, 1, 0, 0, 2'b10, 0, 1, 2'b01, 2'b00);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 2'b00);

    foreach (vq[i]) begin
      rst = vq[i].rst; rd = vq[i].rd; wr = vq[i].wr;
      bc[0] = vq[i].bc0; bc[1] = vq[i].bc1; swait = vq[i].sw; srdv = vq[i].rv;
      #1;
      chk($sformatf("v%0d.grant", i), 32'(grant), 32'(vq[i].eg));
      chk($sformatf("v%0d.s_read", i), 32'(s_read), 32'(vq[i].esr));
      chk($sformatf("v%0d.s_write", i), 32'(s_write), 32'(vq[i].esw));
      chk($sformatf("v%0d.m_waitrequest", i), 32'(m_waitrequest), 32'(vq[i].emw));
      chk($sformatf("v%0d.m_readdatavalid", i), 32'(m_readdatavalid), 32'(vq[i].erv));
      tick();
    end
    rst = 1'b0;

    // Contention after reset: both ports stream 8-beat writes
    rst = 1'b1; tick(); rst = 1'b0;
    wr = 2'b11; rd = 2'b00; bc[0] = 7'd8; bc[1] = 7'd8; swait = 1'b0; srdv = 1'b0;
    prev_g = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      cmp_model();
      if (grant != '0 && grant != prev_g) gq.push_back(grant);
      prev_g = grant;
      tick();
    end
    chk("cont_bursts", 32'(gq.size() >= 3), 32'h1);
    if (gq.size() >= 3) begin
      chk("cont_g0", 32'(gq[0]), 32'h1);
      chk("cont_g1", 32'(gq[1]), 32'h2);
      chk("cont_g2", 32'(gq[2]), 32'h1);
    end
    wr = '0;
    rst = 1'b1; tick(); rst = 1'b0;

    // Read with stalled return: port 1, burstcount 3, strobes at +5, +6, +9
    rv1 = 0; rv0 = 0;
    bc[1] = 7'd3;
    for (int c = 0; c < 15; c++) begin
      rd = (c < 2) ? 2'b10 : 2'b00;
      srdv = (c == 5 || c == 6 || c == 9);
      sdata = DW'(16'h5a00 + c);
      #1;
      cmp_model();
      if (m_readdatavalid[1]) rv1++;
      if (m_readdatavalid[0]) rv0++;
      tick();
    end
    srdv = 1'b0;
    #1;
    chk("rd_pulses_p1", 32'(rv1), 32'd3);
    chk("rd_pulses_p0", 32'(rv0), 32'd0);
    chk("rd_released", 32'(grant), 32'h0);

    // Random traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      rd = NP'($urandom_range(0, 3)) & {NP{$urandom_range(0, 2) == 0}};
      wr = NP'($urandom_range(0, 3)) & {NP{$urandom_range(0, 1) == 0}};
      for (int p = 0; p < NP; p++) begin
        bc[p]   = BW'($urandom_range(0, 4));
        addr[p] = AW'($urandom);
        wd[p]   = DW'($urandom);
        be[p]   = BEW'($urandom);
      end
      swait = ($urandom_range(0, 3) == 0);
      srdv  = ($urandom_range(0, 2) == 0);
      sdata = DW'($urandom);
      #1;
      cmp_model();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
